sad_best_match: RTL

- Consumes the SAD results leaving the parallel SAD threads: a per-lane 14-bit value, 16-bit candidate index and trigger (valid) bit.
- Tracks the minimum SAD and its candidate index across one full search.
- Signals completion once a programmed number of candidates has been absorbed.
- Sits directly downstream of the thread array and feeds the motion-vector / result writeback logic.

---
 rtl/sad_best_match.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sad_best_match.sv
// sad_best_match: folds the per-lane SAD results from the thread array into a
// running minimum (value + candidate index) and flags completion once the
// programmed number of candidates has been absorbed.
module sad_best_match #(
  parameter int NUM_LANES = 4,
  parameter int VAL_W     = 14,
  parameter int IDX_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       Start,
  input  logic [IDX_W-1:0]           NumCandidates,
  input  logic [NUM_LANES*VAL_W-1:0] InValue,
  input  logic [NUM_LANES*IDX_W-1:0] InIndex,
  input  logic [NUM_LANES-1:0]       InTrigger,
  output logic [VAL_W-1:0]           BestValue,
  output logic [IDX_W-1:0]           BestIndex,
  output logic [IDX_W-1:0]           Count,
  output logic                       Busy,
  output logic                       Done
);

  localparam int POP_W = $clog2(NUM_LANES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  // Stage-1 pipeline register: the reduced result of one cycle of lanes
  logic             s1_valid;
  logic [VAL_W-1:0] s1_value;
  logic [IDX_W-1:0] s1_index;
  logic [POP_W-1:0] s1_pop;

  // Stage-2 state: running best, absorbed count and the latched target
  logic [VAL_W-1:0] best_value_q;
  logic [IDX_W-1:0] best_index_q;
  logic [IDX_W-1:0] count_q;
  logic [IDX_W-1:0] target_q;

  // Combinational lane reduction results
  logic [VAL_W-1:0] lane_min_value;
  logic [IDX_W-1:0] lane_min_index;
  logic [POP_W-1:0] lane_pop;
  logic             lane_any;
  logic [VAL_W-1:0] cand_value;
  logic [IDX_W-1:0] cand_index;

  // Stage-2 decision terms
  logic [IDX_W:0]   count_sum;
  logic             target_hit;
  logic             take_best;
  logic             absorb;

  // Min-reduce over the triggered lanes; equal values resolve to the smaller index
  always_comb begin
    lane_min_value = '1;
    lane_min_index = '0;
    lane_pop       = '0;
    lane_any       = 1'b0;
    cand_value     = '0;
    cand_index     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (InTrigger[i]) begin
        cand_value = InValue[i*VAL_W +: VAL_W];
        cand_index = InIndex[i*IDX_W +: IDX_W];
        if (!lane_any || (cand_value < lane_min_value) ||
            ((cand_value == lane_min_value) && (cand_index < lane_min_index))) begin
          lane_min_value = cand_value;
          lane_min_index = cand_index;
        end
        lane_any = 1'b1;
        lane_pop = lane_pop + POP_W'(1);
      end
    end
  end

  // Stage-2 compare and the widened count sum, which cannot wrap before saturation
  always_comb begin
    count_sum  = (IDX_W+1)'(count_q) + (IDX_W+1)'(s1_pop);
    target_hit = (count_sum >= {1'b0, target_q});
    take_best  = (s1_value < best_value_q) ||
                 ((s1_value == best_value_q) && (s1_index < best_index_q));
    absorb     = (state_q == ST_SEARCH) && s1_valid;
  end

  // Next-state logic: Start always wins and restarts; an update reaching the target finishes
  always_comb begin
    state_d = state_q;
    if (Start) begin
      state_d = (NumCandidates == '0) ? ST_DONE : ST_SEARCH;
    end else if (absorb && target_hit) begin
      state_d = ST_DONE;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage 1 only captures lanes while searching; Start or any other state flushes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_value <= '0;
      s1_index <= '0;
      s1_pop   <= '0;
    end else if (Start || (state_q != ST_SEARCH)) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= lane_any;
      s1_value <= lane_min_value;
      s1_index <= lane_min_index;
      s1_pop   <= lane_pop;
    end
  end

  // Stage 2 folds the stage-1 result into the running best and saturates the count at target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_value_q <= '1;
      best_index_q <= '0;
      count_q      <= '0;
      target_q     <= '0;
    end else if (Start) begin
      best_value_q <= '1;
      best_index_q <= '0;
      count_q      <= '0;
      target_q     <= NumCandidates;
    end else if (absorb) begin
      if (take_best) begin
        best_value_q <= s1_value;
        best_index_q <= s1_index;
      end
      count_q <= target_hit ? target_q : count_sum[IDX_W-1:0];
    end
  end

  assign BestValue = best_value_q;
  assign BestIndex = best_index_q;
  assign Count     = count_q;
  assign Busy      = (state_q == ST_SEARCH);
  assign Done      = (state_q == ST_DONE);

endmodule
